rst_seq_gen: RTL and testbench
==============================

// Module: rst_seq_gen
// PURPOSE
//  Reset sequencer: generates ordered, stretched, glitch-free active-high resets for
//  NUM_DOMAINS downstream domains. Each domain's per-domain reset synchronizer
//  consumes one output. Accepts power-on reset (RST) and a level software request (RST_REQ).
//  Domains are released one at a time, index 0 first: CLK_DIV, then the sync blocks,
//  then the cores. Sits in the always-on reference clock domain.
// PARAMETERS
//  NUM_DOMAINS  3   number of reset outputs, >=1
//  HOLD_CYCLES  16  CLK edges all outputs stay asserted after the reset source goes away, >=1
//  GAP_CYCLES   4   CLK edges between successive domain releases, >=1
//  CNT_WIDTH    8   counter width; must hold max(HOLD_CYCLES,GAP_CYCLES)-1
// PORTS
//  CLK          in   1            reference clock
//  RST          in   1            async reset, active-high
//  RST_REQ      in   1            software reset request, level, synchronous to CLK
//  RST_OUT      out  NUM_DOMAINS  per-domain reset, active-high, registered
//  BUSY         out  1            high while any RST_OUT bit is asserted
//  REQ_ACK      out  1            1-cycle pulse: RST_REQ rising edge accepted
//  DONE         out  1            1-cycle pulse: last domain released
// BEHAVIOUR
//  - Reset (RST=1, async): RST_OUT=all 1s, BUSY=1, REQ_ACK=0, DONE=0, state=HOLD,
//    cnt=0, idx=0, req_q=0. RST_OUT asserts immediately, with no clock needed.
//  - States: HOLD, RELEASE, IDLE. All outputs come from flops, with no combinational paths.
//  - HOLD: RST_OUT=all 1s. cnt increments each edge while RST_REQ=0.
//    At the edge where cnt==HOLD_CYCLES-1: RST_OUT[0]<=0, cnt<=0, idx<=1, go to RELEASE.
//    If NUM_DOMAINS==1, go directly to IDLE with DONE<=1 on that same edge.
//  - RELEASE: cnt increments. At the edge where cnt==GAP_CYCLES-1: RST_OUT[idx]<=0, cnt<=0, idx++.
//    On the edge that releases index NUM_DOMAINS-1: DONE<=1, BUSY<=0, go to IDLE.
//  - IDLE: RST_OUT=0, BUSY=0. Stays until RST_REQ.
//  - Release timing from the first CLK edge after RST falls:
//    RST_OUT[i] falls HOLD_CYCLES + i*GAP_CYCLES edges later.
//    Defaults: bit0 @16, bit1 @20, bit2 @24. DONE is high during cycle 24.
//  - RST_REQ=1 in any state (highest priority after RST): next edge RST_OUT<=all 1s,
//    BUSY<=1, cnt<=0, idx<=0, state<=HOLD. The HOLD count does not start until RST_REQ=0,
//    so a long request stretches the reset.
//    A request during RELEASE re-asserts already-released domains.
//  - REQ_ACK: req_q registers RST_REQ. REQ_ACK<=RST_REQ & ~req_q, one pulse per rising edge.
//  - Simultaneous RST_REQ rise and final release edge: the request wins.
//    RST_OUT returns to all 1s, DONE stays 0, and REQ_ACK pulses.
//  - RST mid-sequence: async return to the reset values. Sequence restarts from HOLD, cnt=0.
//  - Bits already released never re-assert except via RST or RST_REQ.
//    Bits never deassert out of index order.
//  - Counters never wrap in normal operation. cnt compares use ==, and cnt is cleared on
//    every state change.
// STRUCTURE
//  - Shared package rst_pkg: state encoding localparams ST_HOLD=2'd0, ST_RELEASE=2'd1,
//    ST_IDLE=2'd2, and the function clog2, used for the idx width.
//  - One sub-module: rst_tick_cnt. It is a CNT_WIDTH counter with a clear input, an enable
//    input and a terminal-count compare to a runtime limit, reused for both the HOLD and
//    GAP phases.
//  - FSM, idx register and output registers live in rst_seq_gen.
// TESTING
//  1 Power-on: RST=1 for 20ns, then 0 (10ns CLK) -> RST_OUT=3'b111 until edge 16,
//    then 3'b110 @16, 3'b100 @20, 3'b000 @24. DONE pulses at 24; BUSY falls at 24.
//  2 Async assert: RST=1 mid-cycle at edge 18 -> RST_OUT=3'b111 within the same cycle,
//    with no CLK edge. After release, the full 16/20/24 timing is repeated.
//  3 SW request in IDLE: 1-cycle RST_REQ pulse -> next edge RST_OUT=3'b111 and
//    REQ_ACK=1 for 1 cycle. Releases follow at +16/+20/+24 edges after RST_REQ falls.
//  4 Stretched request: RST_REQ held 40 cycles -> RST_OUT stays 3'b111 throughout.
//    REQ_ACK pulses once. Bit0 releases 16 edges after RST_REQ falls.
//  5 Request during RELEASE, arriving after bit0 is released (3'b110): -> next edge 3'b111
//    with a fresh 16/20/24 sequence. No DONE from the aborted sequence.
//  6 Collision: RST_REQ rises on the edge that would release bit2 -> RST_OUT=3'b111,
//    DONE=0, REQ_ACK=1.
//    Also rerun with NUM_DOMAINS=1, HOLD_CYCLES=1: bit0 falls 1 edge after RST,
//    with DONE on the same edge.

Source files
------------

// File: rtl/rst_seq_gen_pkg.sv
// Shared definitions for the reset sequencer: state encoding and a width helper.
package rst_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_IDLE    = 2'd2;

  typedef enum logic [1:0] {
    HOLD    = ST_HOLD,
    RELEASE = ST_RELEASE,
    IDLE    = ST_IDLE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Request/status bundle between the reset sequencer and its controller.
interface rst_seq_gen_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   rst_req;
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   busy;
  logic                   req_ack;
  logic                   done;

  modport master (input rst_req, output rst_out, busy, req_ack, done);
  modport slave  (output rst_req, input rst_out, busy, req_ack, done);
endinterface

// File: rtl/rst_seq_gen_tick_cnt.sv
// Cycle counter with clear/enable and terminal-count compare against a runtime limit.
module rst_tick_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 tc
);
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == limit);
endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds all domains in reset, then releases them one by one, index 0 first.
module rst_seq_gen
  import rst_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rst_seq_gen_if.master        bus
);
  localparam int IDX_W = clog2(NUM_DOMAINS + 1);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [NUM_DOMAINS-1:0] rst_out_q;
  logic                   busy_q, req_ack_q, done_q, req_q;
  logic                   tc, cnt_clr, cnt_en;
  logic [CNT_WIDTH-1:0]   cnt_lim;

  // The counter restarts on every state change and is held at zero while a request is active.
  assign cnt_lim = (state == HOLD) ? CNT_WIDTH'(HOLD_CYCLES - 1) : CNT_WIDTH'(GAP_CYCLES - 1);
  assign cnt_en  = (state != IDLE);
  assign cnt_clr = bus.rst_req | (state == IDLE) | tc;

  rst_tick_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (cnt_lim),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      idx       <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      req_ack_q <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      req_q     <= bus.rst_req;
      req_ack_q <= bus.rst_req & ~req_q;
      done_q    <= 1'b0;
      if (bus.rst_req) begin
        // A request outranks any release due on this same edge.
        rst_out_q <= '1;
        busy_q    <= 1'b1;
        idx       <= '0;
        state     <= HOLD;
      end else begin
        case (state)
          HOLD: begin
            rst_out_q <= '1;
            if (tc) begin
              rst_out_q[0] <= 1'b0;
              idx          <= IDX_W'(1);
              if (NUM_DOMAINS == 1) begin
                state  <= IDLE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (tc) begin
              for (int i = 0; i < NUM_DOMAINS; i++)
                if (IDX_W'(i) == idx) rst_out_q[i] <= 1'b0;
              idx <= idx + 1'b1;
              if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
                state  <= IDLE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end
          end
          IDLE: begin
            rst_out_q <= '0;
            busy_q    <= 1'b0;
          end
          default: state <= HOLD;
        endcase
      end
    end
  end

  assign bus.rst_out = rst_out_q;
  assign bus.busy    = busy_q;
  assign bus.req_ack = req_ack_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench: default 3-domain sequencer plus a 1-domain, 1-cycle-hold instance.
module tb_rst_seq_gen;
  logic clk, rst;

  rst_seq_gen_if #(.NUM_DOMAINS(3)) bus0 ();
  rst_seq_gen_if #(.NUM_DOMAINS(1)) bus1 ();

  rst_seq_gen #(.NUM_DOMAINS(3), .HOLD_CYCLES(16), .GAP_CYCLES(4), .CNT_WIDTH(8)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.master)
  );
  rst_seq_gen #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(4), .CNT_WIDTH(8)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    int         n;
    logic [2:0] out;
    logic       busy;
    logic       ack;
    logic       done;
  } vec_t;

  vec_t tbl[$];
  int   run_ptr = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic add(input logic req, input int n, input logic [2:0] out,
                     input logic busy, input logic ack, input logic done);
    vec_t v;
    v.req = req; v.n = n; v.out = out; v.busy = busy; v.ack = ack; v.done = done;
    tbl.push_back(v);
  endtask

  // Full release sequence counted from the first edge with the request low.
  task automatic std_rows(input int first_hold);
    add(1'b0, first_hold, 3'b111, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4,          3'b110, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4,          3'b100, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1,          3'b000, 1'b0, 1'b0, 1'b1);
    add(1'b0, 2,          3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step(input logic req);
    bus0.rst_req = req;
    @(posedge clk);
    #1;
  endtask

  task automatic run_pending();
    while (run_ptr < tbl.size()) begin
      for (int e = 0; e < tbl[run_ptr].n; e++) begin
        step(tbl[run_ptr].req);
        chk($sformatf("r%0d.%0d out", run_ptr, e),  32'(bus0.rst_out), 32'(tbl[run_ptr].out));
        chk($sformatf("r%0d.%0d busy", run_ptr, e), 32'(bus0.busy),    32'(tbl[run_ptr].busy));
        chk($sformatf("r%0d.%0d ack", run_ptr, e),  32'(bus0.req_ack), 32'(tbl[run_ptr].ack));
        chk($sformatf("r%0d.%0d done", run_ptr, e), 32'(bus0.done),    32'(tbl[run_ptr].done));
      end
      run_ptr++;
    end
  endtask

  // First two edges after reset release: the 1-domain instance finishes on edge 1.
  task automatic post_reset_edges(input string tag);
    step(1'b0);
    chk({tag, " e1 out0"},  32'(bus0.rst_out), 32'h7);
    chk({tag, " e1 out1"},  32'(bus1.rst_out), 32'h0);
    chk({tag, " e1 done1"}, 32'(bus1.done),    32'h1);
    chk({tag, " e1 busy1"}, 32'(bus1.busy),    32'h0);
    step(1'b0);
    chk({tag, " e2 out0"},  32'(bus0.rst_out), 32'h7);
    chk({tag, " e2 done1"}, 32'(bus1.done),    32'h0);
    chk({tag, " e2 out1"},  32'(bus1.rst_out), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus0.rst_req = 1'b0;
    bus1.rst_req = 1'b0;
    #2;
    chk("por out0",  32'(bus0.rst_out), 32'h7);
    chk("por busy0", 32'(bus0.busy),    32'h1);
    chk("por ack0",  32'(bus0.req_ack), 32'h0);
    chk("por done0", 32'(bus0.done),    32'h0);
    chk("por out1",  32'(bus1.rst_out), 32'h1);
    #18 rst = 1'b0;

    // Power-on release: bit0 @16, bit1 @20, bit2 @24
    post_reset_edges("por");
    std_rows(13);
    run_pending();

    // Single-cycle software request from IDLE
    add(1'b1, 1, 3'b111, 1'b1, 1'b1, 1'b0);
    std_rows(15);
    // Request held 40 cycles stretches the reset
    add(1'b1, 1,  3'b111, 1'b1, 1'b1, 1'b0);
    add(1'b1, 39, 3'b111, 1'b1, 1'b0, 1'b0);
    std_rows(15);
    // Request after bit0 released aborts the sequence
    add(1'b1, 1,  3'b111, 1'b1, 1'b1, 1'b0);
    add(1'b0, 15, 3'b111, 1'b1, 1'b0, 1'b0);
    add(1'b0, 2,  3'b110, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1,  3'b111, 1'b1, 1'b1, 1'b0);
    std_rows(15);
    // Request rising on the final release edge wins
    add(1'b1, 1,  3'b111, 1'b1, 1'b1, 1'b0);
    add(1'b0, 15, 3'b111, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4,  3'b110, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4,  3'b100, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1,  3'b111, 1'b1, 1'b1, 1'b0);
    std_rows(15);
    // Reach edge 18 of a sequence for the async reset check
    add(1'b1, 1,  3'b111, 1'b1, 1'b1, 1'b0);
    add(1'b0, 15, 3'b111, 1'b1, 1'b0, 1'b0);
    add(1'b0, 3,  3'b110, 1'b1, 1'b0, 1'b0);
    run_pending();

    // Async reset mid-cycle, no clock edge in between
    #3 rst = 1'b1;
    #1;
    chk("async out0",  32'(bus0.rst_out), 32'h7);
    chk("async busy0", 32'(bus0.busy),    32'h1);
    chk("async out1",  32'(bus1.rst_out), 32'h1);
    chk("async busy1", 32'(bus1.busy),    32'h1);
    #2 rst = 1'b0;
    post_reset_edges("arst");
    std_rows(13);
    run_pending();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
